serial_tx_fifo: RTL and testbench

//   Byte FIFO between the bus-facing data register and the serial transmitter
//   of the UART peripheral.
//   - The bus side pushes bytes. The transmitter pops one byte per frame when idle.
//   - Lets software queue several bytes without polling the TX event flag per byte.
//   - Exposes level, threshold and overflow status for the status register and IRQ logic.
//

---
 rtl/serial_tx_fifo_if.sv | 23 ++
 rtl/serial_tx_fifo.sv | 78 +++++++
 tb/tb_serial_tx_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_fifo_if.sv
// Push/pop handshake bundle between the bus-side data register and the TX FIFO.
// A transfer happens on a rising edge where valid && ready. Valid never depends on ready.
interface serial_tx_fifo_if #(
  parameter int WIDTH = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  // master: bus writer plus transmitter; slave: the FIFO
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the UART serial transmitter, with first-word fall-through,
// level/threshold status and a sticky overflow flag.
module serial_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  serial_tx_fifo_if.slave            bus,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       low_water,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             ovf_event;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign low_water = (level <= LW'(THRESHOLD));

  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;
  assign bus.rd_data  = mem[rd_ptr];

  assign push      = bus.wr_valid && !full;
  assign pop       = !empty && bus.rd_ready;
  assign ovf_event = bus.wr_valid && full;

  // Storage is deliberately left unreset; rd_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A fresh overflow in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: status, ordering, wrap, overflow, flush and reset.
module tb_serial_tx_fifo;
  logic       clk;
  logic       reset;
  logic       flush;
  logic       clear_overflow;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       low_water;
  logic       overflow;

  serial_tx_fifo_if #(.WIDTH(8)) bus ();

  serial_tx_fifo #(.DEPTH(16), .WIDTH(8), .THRESHOLD(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .level          (level),
    .full           (full),
    .empty          (empty),
    .low_water      (low_water),
    .overflow       (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         exp_lvl;
  logic       exp_ovf;
  int         n_vec;
  int         n_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".level"},     32'(level),          32'(exp_lvl));
    check({tag, ".full"},      32'(full),           32'(exp_lvl == 16));
    check({tag, ".empty"},     32'(empty),          32'(exp_lvl == 0));
    check({tag, ".low_water"}, 32'(low_water),      32'(exp_lvl <= 4));
    check({tag, ".wr_ready"},  32'(bus.wr_ready),   32'(exp_lvl != 16));
    check({tag, ".rd_valid"},  32'(bus.rd_valid),   32'(exp_lvl != 0));
    check({tag, ".overflow"},  32'(overflow),       32'(exp_ovf));
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.rd_ready   = 1'b0;
    flush          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    exp_q.push_back(d);
    exp_lvl++;
  endtask

  task automatic pop_byte(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(e));
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    exp_lvl--;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_lvl = 0;
    exp_ovf = 1'b0;
    reset   = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1. reset then idle
    check_status("t1_reset");
    tick();
    check_status("t1_idle");

    // 2. three pushes then three pops
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h53;
    check(".t2_rd_valid_before", 32'(bus.rd_valid), 32'd0);
    tick();
    exp_q.push_back(8'h53);
    exp_lvl = 1;
    check("t2_rd_valid_after_push", 32'(bus.rd_valid), 32'd1);
    check("t2_head", 32'(bus.rd_data), 32'h53);
    bus.wr_valid = 1'b0;
    push_byte(8'hCA);
    push_byte(8'h01);
    check_status("t2_lvl3");
    for (int i = 0; i < 3; i++) pop_byte("t2_pop");
    check_status("t2_end");

    // 3. fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      check_status("t3_fill");
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hFF;
    tick();
    bus.wr_valid = 1'b0;
    exp_ovf = 1'b1;
    check_status("t3_overflow");
    for (int i = 0; i < 16; i++) pop_byte("t3_drain");
    check_status("t3_drained");
    check("t3_no_ff", 32'(bus.rd_valid), 32'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    check_status("t3_clear");

    // 4. steady push+pop at level 7 across wrap, then push+pop while full
    for (int i = 0; i < 7; i++) push_byte(8'h10 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      check("t4_stream.rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h20 + 8'(i);
      bus.rd_ready = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(8'h20 + 8'(i));
      check("t4_stream.level", 32'(level), 32'd7);
    end
    idle_inputs();
    for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i));
    check_status("t4_full");
    check("t4_full_head", 32'(bus.rd_data), 32'(exp_q[0]));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    bus.rd_ready = 1'b1;
    tick();
    idle_inputs();
    void'(exp_q.pop_front());
    exp_lvl = 15;
    exp_ovf = 1'b1;
    check_status("t4_pop_at_full");

    // 5. flush at level 10 with push and pop presented
    for (int i = 0; i < 5; i++) pop_byte("t4_drain");
    check_status("t5_lvl10");
    flush        = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hAA;
    bus.rd_ready = 1'b1;
    tick();
    idle_inputs();
    exp_q.delete();
    exp_lvl = 0;
    check_status("t5_flushed");
    tick();
    check_status("t5_after");
    push_byte(8'h5A);
    check("t5_fresh_head", 32'(bus.rd_data), 32'h5A);
    pop_byte("t5_pop");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    check_status("t5_clear");

    // 6. overflow priority, then asynchronous reset mid-burst
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    tick();
    exp_ovf = 1'b1;
    check_status("t6_ovf");
    clear_overflow = 1'b1;
    tick();
    check_status("t6_clear_and_push");
    bus.wr_valid = 1'b0;
    tick();
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    check_status("t6_clear_alone");
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    exp_ovf = 1'b1;
    for (int i = 0; i < 7; i++) pop_byte("t6_drain");
    check_status("t6_lvl9");
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hC3;
    bus.rd_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_lvl = 0;
    exp_ovf = 1'b0;
    check_status("t6_async_reset");
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    check_status("t6_released");
    push_byte(8'h77);
    pop_byte("t6_after_reset");
    check_status("t6_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
